// File: rtl/gemm_job_scheduler.sv
// GeMM job scheduler: buffers job descriptors in a FIFO, launches them one at a time
// and returns one completion per job. `GEMM_SCHED_PERF_EN adds a per-job cycle counter.
module gemm_job_scheduler #(
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdWidth    = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [IdWidth-1:0]                 job_id_i,
  input  logic [AddrWidth-1:0]               job_M_i,
  input  logic [AddrWidth-1:0]               job_K_i,
  input  logic [AddrWidth-1:0]               job_N_i,
  output logic                               gemm_start_o,
  output logic [AddrWidth-1:0]               gemm_M_size_o,
  output logic [AddrWidth-1:0]               gemm_K_size_o,
  output logic [AddrWidth-1:0]               gemm_N_size_o,
  input  logic                               gemm_busy_i,
  input  logic                               gemm_done_i,
  output logic                               cmpl_valid_o,
  input  logic                               cmpl_ready_i,
  output logic [IdWidth-1:0]                 cmpl_id_o,
  output logic                               cmpl_error_o,
  output logic [$clog2(QueueDepth+1)-1:0]    queue_count_o,
`ifdef GEMM_SCHED_PERF_EN
  output logic [31:0]                        cmpl_cycles_o,
`endif
  output logic                               idle_o
);

  localparam int unsigned PtrW = $clog2(QueueDepth);
  localparam int unsigned CntW = $clog2(QueueDepth + 1);
  localparam int unsigned EntW = IdWidth + 3 * AddrWidth;
  localparam logic [CntW-1:0] CntFull = CntW'(QueueDepth);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StRun    = 2'd2,
    StReport = 2'd3
  } state_e;

  state_e               state_q;
  logic [EntW-1:0]      mem_q [QueueDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 start_q, valid_q, err_q;
  logic [IdWidth-1:0]   act_id_q;
  logic [AddrWidth-1:0] act_m_q, act_k_q, act_n_q;
  logic [IdWidth-1:0]   head_id_s;
  logic [AddrWidth-1:0] head_m_s, head_k_s, head_n_s;
  logic                 push_s, pop_s, empty_s, zero_s;

  // Ready is derived only from the registered count, so pop never reaches it combinationally.
  assign job_ready_o = (count_q != CntFull);
  assign empty_s     = (count_q == '0);
  assign push_s      = job_valid_i && job_ready_o;
  assign pop_s       = (state_q == StIdle) && !empty_s && !gemm_busy_i;
  assign {head_id_s, head_m_s, head_k_s, head_n_s} = mem_q[rd_ptr_q];
  assign zero_s      = (head_m_s == '0) || (head_k_s == '0) || (head_n_s == '0);

  assign gemm_start_o  = start_q;
  assign cmpl_valid_o  = valid_q;
  assign cmpl_id_o     = act_id_q;
  assign cmpl_error_o  = err_q;
  assign gemm_M_size_o = act_m_q;
  assign gemm_K_size_o = act_k_q;
  assign gemm_N_size_o = act_n_q;
  assign queue_count_o = count_q;
  assign idle_o        = (state_q == StIdle) && empty_s;

  // Occupancy next-state from push/pop.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CntW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CntW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO pointers and count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= {job_id_i, job_M_i, job_K_i, job_N_i};
  end

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] cyc_q;
  assign cmpl_cycles_o = cyc_q;
`endif

  // Job FSM with registered start/completion outputs and active job registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      act_id_q <= '0;
      act_m_q  <= '0;
      act_k_q  <= '0;
      act_n_q  <= '0;
`ifdef GEMM_SCHED_PERF_EN
      cyc_q    <= 32'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (pop_s) begin
            act_id_q <= head_id_s;
            act_m_q  <= head_m_s;
            act_k_q  <= head_k_s;
            act_n_q  <= head_n_s;
`ifdef GEMM_SCHED_PERF_EN
            cyc_q    <= 32'd0;
`endif
            if (zero_s) begin
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= StReport;
            end else begin
              err_q   <= 1'b0;
              start_q <= 1'b1;
              state_q <= StLaunch;
            end
          end
        end
        StLaunch: begin
          start_q <= 1'b0;
`ifdef GEMM_SCHED_PERF_EN
          cyc_q   <= 32'd1;
`endif
          state_q <= StRun;
        end
        StRun: begin
          // The done cycle itself is counted, so the increment also happens on done.
`ifdef GEMM_SCHED_PERF_EN
          if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
`endif
          if (gemm_done_i) begin
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StReport;
          end
        end
        StReport: begin
          if (cmpl_ready_i) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          start_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
